// File: rtl/ula_seq_pkg.sv
// Shared definitions for the sequential ALU: select codes,
// shift-mode encoding and small decode helpers.
package ula_seq_pkg;

    localparam logic [3:0] ULA_ADD   = 4'd1;
    localparam logic [3:0] ULA_SUB   = 4'd2;
    localparam logic [3:0] ULA_SLL   = 4'd3;
    localparam logic [3:0] ULA_SLT   = 4'd4;
    localparam logic [3:0] ULA_SLTU  = 4'd5;
    localparam logic [3:0] ULA_SRL   = 4'd6;
    localparam logic [3:0] ULA_SRA   = 4'd7;
    localparam logic [3:0] ULA_XOR   = 4'd8;
    localparam logic [3:0] ULA_OR    = 4'd9;
    localparam logic [3:0] ULA_AND   = 4'd10;
    localparam logic [3:0] ULA_LUI   = 4'd11;
    localparam logic [3:0] ULA_AUIPC = 4'd12;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } sh_mode_t;

    function automatic logic is_shift_op(input logic [3:0] s);
        return (s == ULA_SLL) || (s == ULA_SRL) || (s == ULA_SRA);
    endfunction

    function automatic logic is_legal_op(input logic [3:0] s);
        return (s != 4'd0) && (s <= ULA_AUIPC);
    endfunction

    function automatic sh_mode_t sh_mode_of(input logic [3:0] s);
        sh_mode_t m;
        m = SH_SLL;
        if (s == ULA_SRL) m = SH_SRL;
        if (s == ULA_SRA) m = SH_SRA;
        return m;
    endfunction

endpackage

// File: rtl/ula_shift_unit.sv
// Iterative shifter: one bit per step, counts down the shift amount
// and flags the final step so the FSM can retire the result.
module ula_shift_unit
    import ula_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [1:0]         mode_in,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   shifted,
    output logic               last
);

    sh_mode_t           mode;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;

    always_comb begin
        shifted = acc;
        case (mode)
            SH_SLL:  shifted = {acc[WIDTH-2:0], 1'b0};
            SH_SRL:  shifted = {1'b0, acc[WIDTH-1:1]};
            SH_SRA:  shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
            default: shifted = acc;
        endcase
    end

    assign last = (cnt == SHAMT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            cnt  <= '0;
            mode <= SH_SLL;
        end else if (load) begin
            acc  <= op_a;
            cnt  <= shamt;
            mode <= sh_mode_t'(mode_in);
        end else if (step) begin
            acc <= shifted;
            cnt <= cnt - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/ula_seq.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith ops, shifts run
// one bit per cycle behind a start/busy/done handshake.
module ula_seq
    import ula_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ula_select,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic               accept;
    logic               long_shift;
    logic               sh_load;
    logic               sh_step;
    logic               sh_last;
    logic [WIDTH-1:0]   sh_next;
    logic [WIDTH-1:0]   alu_res;
    logic [SHAMT_W-1:0] shamt;

    assign shamt      = op_b[SHAMT_W-1:0];
    assign accept     = start && (state != S_SHIFT);
    assign long_shift = is_shift_op(ula_select) && (shamt != '0);

    always_comb begin
        alu_res = '0;
        case (ula_select)
            ULA_ADD:   alu_res = op_a + op_b;
            ULA_SUB:   alu_res = op_a - op_b;
            ULA_SLT:   alu_res = {{(WIDTH-1){1'b0}},
                                  $signed(op_a) < $signed(op_b)};
            ULA_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
            ULA_XOR:   alu_res = op_a ^ op_b;
            ULA_OR:    alu_res = op_a | op_b;
            ULA_AND:   alu_res = op_a & op_b;
            ULA_LUI:   alu_res = op_b;
            ULA_AUIPC: alu_res = op_a + op_b;
            // zero-length shifts pass op_a straight through
            ULA_SLL,
            ULA_SRL,
            ULA_SRA:   alu_res = op_a;
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        sh_load  = 1'b0;
        sh_step  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (long_shift) begin
                        sh_load  = 1'b1;
                        state_nx = S_SHIFT;
                    end else begin
                        state_nx = S_DONE;
                    end
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_SHIFT: begin
                sh_step = 1'b1;
                if (sh_last) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (accept && !long_shift) begin
            result  <= alu_res;
            zero    <= (alu_res == '0);
            illegal <= !is_legal_op(ula_select);
        end else if (accept) begin
            illegal <= 1'b0;
        end else if (state == S_SHIFT && sh_last) begin
            result <= sh_next;
            zero   <= (sh_next == '0);
        end
    end

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

    ula_shift_unit #(
        .WIDTH  (WIDTH),
        .SHAMT_W(SHAMT_W)
    ) u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (sh_load),
        .step   (sh_step),
        .mode_in(sh_mode_of(ula_select)),
        .op_a   (op_a),
        .shamt  (shamt),
        .shifted(sh_next),
        .last   (sh_last)
    );

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: directed cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_ula_seq;
    import ula_seq_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   sel = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, zero, illegal;
    logic [W-1:0] result;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         ill;
        int           exp_cyc;
    } exp_t;

    exp_t q[$];

    ula_seq #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ula_select(sel),
        .op_a      (a),
        .op_b      (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [3:0] s,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input int now);
        exp_t e;
        int   n;
        n         = int'(y[4:0]);
        e.res     = '0;
        e.ill     = 1'b0;
        e.exp_cyc = now + 1;
        case (s)
            ULA_ADD:   e.res = x + y;
            ULA_SUB:   e.res = x - y;
            ULA_SLT:   e.res = ($signed(x) < $signed(y)) ? 1 : 0;
            ULA_SLTU:  e.res = (x < y) ? 1 : 0;
            ULA_XOR:   e.res = x ^ y;
            ULA_OR:    e.res = x | y;
            ULA_AND:   e.res = x & y;
            ULA_LUI:   e.res = y;
            ULA_AUIPC: e.res = x + y;
            ULA_SLL:   e.res = x << n;
            ULA_SRL:   e.res = x >> n;
            ULA_SRA:   e.res = $signed(x) >>> n;
            default: begin
                e.res = '0;
                e.ill = 1'b1;
            end
        endcase
        if ((s == ULA_SLL || s == ULA_SRL || s == ULA_SRA) && n > 0)
            e.exp_cyc = now + n + 1;
        return e;
    endfunction

    task automatic chk(input string nm,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (q.size() > 0 && !done && cyc > q[0].exp_cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL late_done: got none expected done at cycle %0d",
                         q[0].exp_cyc);
                void'(q.pop_front());
            end
            if (done) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_done: got done=1 expected 0 at cycle %0d",
                             cyc);
                end else begin
                    e = q.pop_front();
                    chk("result", result, e.res);
                    chk("zero", W'(zero), W'(e.res == '0));
                    chk("illegal", W'(illegal), W'(e.ill));
                    chk("latency_cycle", W'(cyc), W'(e.exp_cyc));
                end
            end
        end
    end

    task automatic issue(input logic [3:0] s,
                         input logic [W-1:0] x,
                         input logic [W-1:0] y);
        int guard;
        guard = 0;
        @(negedge clk);
        // scrambled inputs (start still high) must be ignored while busy
        while (busy && guard < 100) begin
            sel = 4'($urandom);
            a   = $urandom;
            b   = $urandom;
            guard++;
            @(negedge clk);
        end
        if (busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL busy_stuck: got busy=1 expected 0");
        end
        sel   = s;
        a     = x;
        b     = y;
        start = 1'b1;
        q.push_back(model(s, x, y, cyc));
    endtask

    task automatic settle();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        settle();
        while (q.size() > 0 && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int dcount;
        logic [3:0]   rs;
        logic [W-1:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("rst_busy", W'(busy), 0);
        chk("rst_done", W'(done), 0);
        chk("rst_result", result, 0);
        chk("rst_zero", W'(zero), 0);
        chk("rst_illegal", W'(illegal), 0);
        rst_n = 1'b1;

        issue(ULA_ADD, 32'hFFFF_FFFF, 32'd1);
        settle();
        issue(ULA_SRA, 32'h8000_0000, 32'd4);
        settle();
        issue(ULA_SLT, 32'hFFFF_FFFF, 32'd1);
        issue(ULA_SLTU, 32'hFFFF_FFFF, 32'd1);
        settle();
        issue(ULA_SLL, 32'h1234_5678, 32'd0);
        issue(ULA_XOR, 32'h0000_00F0, 32'h0000_00FF);
        settle();
        issue(4'd14, 32'h55, 32'hAA);
        settle();
        issue(ULA_SLL, 32'h0000_0001, 32'd31);
        issue(ULA_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        drain();

        issue(ULA_SRL, 32'hDEAD_BEEF, 32'd31);
        settle();
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_busy", W'(busy), 0);
        chk("midrst_done", W'(done), 0);
        chk("midrst_result", result, 0);
        chk("midrst_zero", W'(zero), 0);
        chk("midrst_illegal", W'(illegal), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("post_rst_quiet", W'(dcount), 0);

        for (int i = 0; i < 300; i++) begin
            rs = 4'($urandom);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'h0;
            if ($urandom_range(0, 3) == 0) rb = {rb[W-1:5], 5'($urandom_range(0, 3))};
            issue(rs, ra, rb);
            if ($urandom_range(0, 2) == 0) settle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
